// File: rtl/mux_arb_2x32.sv
// mux_arb_2x32: two-requester arbiter feeding one registered 32-bit output slot
// Ports: CLK/RST (sync active-high); A_VALID/A/A_READY and B_VALID/B/B_READY requesters;
//        Y_VALID/Y/Y_READY/SEL output slot; XFER_CNT accepted-word counter (CNT_W bits).
// Build option MUX_ARB_FIXED_PRI_EN: A always wins ties; default is round-robin.
module mux_2x32 (
  input  logic        sel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  assign y = sel ? b : a;
endmodule

module mux_arb_2x32 #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             A_VALID,
  input  logic [31:0]      A,
  output logic             A_READY,
  input  logic             B_VALID,
  input  logic [31:0]      B,
  output logic             B_READY,
  output logic             Y_VALID,
  output logic [31:0]      Y,
  input  logic             Y_READY,
  output logic             SEL,
  output logic [CNT_W-1:0] XFER_CNT
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nx;
  logic grant, open, accept;
  logic [31:0] mux_y;
`ifdef MUX_ARB_FIXED_PRI_EN
  assign grant = B_VALID & !A_VALID;
`else
  // last: 1 = B served most recently, so a tie goes to A
  logic last;
  assign grant = B_VALID & (!A_VALID | !last);
  always_ff @(posedge CLK)
    if (RST) last <= 1'b1;
    else if (accept) last <= grant;
`endif
  // slot can take a word when empty or when being drained this cycle
  assign open    = (state == EMPTY) | Y_READY;
  assign accept  = open & (A_VALID | B_VALID) & !RST;
  assign A_READY = accept & !grant;
  assign B_READY = accept & grant;
  mux_2x32 u_mux (.sel(grant), .a(A), .b(B), .y(mux_y));
  always_ff @(posedge CLK) state <= state_nx;
  always_comb state_nx = RST ? EMPTY : accept ? FULL : Y_READY ? EMPTY : state;
  always_comb Y_VALID = state == FULL;
  always_ff @(posedge CLK)
    if (RST) begin
      Y        <= '0;
      SEL      <= 1'b0;
      XFER_CNT <= '0;
    end else if (accept) begin
      Y        <= mux_y;
      SEL      <= grant;
      XFER_CNT <= XFER_CNT + CNT_W'(1);
    end
endmodule

// File: tb/tb_mux_arb_2x32.sv
// tb_mux_arb_2x32: scoreboard bench for mux_arb_2x32 (CNT_W=4)
module tb_mux_arb_2x32;
  logic clk = 1'b0, rst, a_valid, b_valid, y_ready;
  logic [31:0] a, b;
  logic a_ready, b_ready, y_valid, sel;
  logic [31:0] y;
  logic [3:0] xfer_cnt;
  int nvec = 0, nerr = 0;
  logic m_full = 1'b0, m_last = 1'b1;
  logic [3:0] m_cnt = '0;
  logic [32:0] q[$];
`ifdef MUX_ARB_FIXED_PRI_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  mux_arb_2x32 #(.CNT_W(4)) dut (
    .CLK(clk), .RST(rst), .A_VALID(a_valid), .A(a), .A_READY(a_ready),
    .B_VALID(b_valid), .B(b), .B_READY(b_ready), .Y_VALID(y_valid), .Y(y),
    .Y_READY(y_ready), .SEL(sel), .XFER_CNT(xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic cycle(input logic r, input logic av, input logic [31:0] ad,
                       input logic bv, input logic [31:0] bd, input logic yr);
    logic gb, ga, acc, er_a, er_b;
    @(negedge clk);
    rst = r; a_valid = av; a = ad; b_valid = bv; b = bd; y_ready = yr;
    #1;
    gb = bv & (!av | (!FIXED & !m_last));
    ga = av & !gb;
    acc = (!m_full | yr) & (av | bv) & !r;
    er_a = acc & ga;
    er_b = acc & gb;
    nvec++;
    if (a_ready !== er_a) begin nerr++; $display("FAIL a_ready: got %b want %b", a_ready, er_a); end
    nvec++;
    if (b_ready !== er_b) begin nerr++; $display("FAIL b_ready: got %b want %b", b_ready, er_b); end
    if (m_full && q.size() > 0) begin
      nvec++;
      if ({sel, y} !== q[0]) begin nerr++; $display("FAIL y_word: got sel=%b y=%0d want sel=%b y=%0d", sel, y, q[0][32], q[0][31:0]); end
      if (yr && !r) void'(q.pop_front());
    end
    if (acc) q.push_back({gb, gb ? bd : ad});
    @(posedge clk);
    #1;
    if (r) begin
      m_full = 1'b0; m_last = 1'b1; m_cnt = '0; q.delete();
    end else begin
      m_full = acc | (m_full & !yr);
      if (acc) begin m_last = gb; m_cnt = m_cnt + 4'd1; end
    end
    nvec++;
    if (xfer_cnt !== m_cnt) begin nerr++; $display("FAIL xfer_cnt: got %0d want %0d", xfer_cnt, m_cnt); end
    nvec++;
    if (y_valid !== m_full) begin nerr++; $display("FAIL y_valid: got %b want %b", y_valid, m_full); end
  endtask

  task automatic test_reset;
    cycle(1, 1, 32'd7, 1, 32'd9, 1);
    cycle(1, 0, 0, 0, 0, 0);
    nvec++;
    if (y !== 32'd0 || sel !== 1'b0) begin nerr++; $display("FAIL reset_y: got sel=%b y=%0d want sel=0 y=0", sel, y); end
  endtask

  task automatic test_single;
    cycle(0, 1, 32'd1, 0, 0, 1);
    nvec++;
    if ({y_valid, sel, y, xfer_cnt} !== {1'b1, 1'b0, 32'd1, 4'd1}) begin
      nerr++; $display("FAIL single: got v=%b sel=%b y=%0d cnt=%0d want v=1 sel=0 y=1 cnt=1", y_valid, sel, y, xfer_cnt);
    end
    cycle(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_round_robin;
    for (int i = 0; i < 8; i++) cycle(0, 1, 32'd1, 1, 32'd3, 1);
    cycle(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_stall;
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 32'd1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 32'd1, 1, 32'd3, 0);
    cycle(0, 1, 32'd1, 1, 32'd3, 1);
    nvec++;
    if (y !== (FIXED ? 32'd1 : 32'd3)) begin nerr++; $display("FAIL stall_release: got y=%0d", y); end
  endtask

  task automatic test_reset_mid;
    cycle(1, 1, 32'd1, 1, 32'd3, 0);
    nvec++;
    if ({y_valid, y, xfer_cnt} !== {1'b0, 32'd0, 4'd0}) begin
      nerr++; $display("FAIL reset_mid: got v=%b y=%0d cnt=%0d want 0 0 0", y_valid, y, xfer_cnt);
    end
    cycle(0, 1, 32'd1, 1, 32'd3, 1);
    nvec++;
    if (sel !== 1'b0 || y !== 32'd1) begin nerr++; $display("FAIL reset_tie: got sel=%b y=%0d want sel=0 y=1", sel, y); end
    cycle(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_wrap;
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 17; i++) begin
      cycle(0, 1, i, 0, 0, 1);
      if (i >= 15) begin
        nvec++;
        if (xfer_cnt !== 4'(i)) begin nerr++; $display("FAIL wrap_%0d: got %0d want %0d", i, xfer_cnt, 4'(i)); end
      end
    end
    cycle(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_fixed_drop;
    cycle(0, 1, 32'd1, 1, 32'd3, 1);
    cycle(0, 1, 32'd1, 1, 32'd3, 1);
    cycle(0, 0, 32'd1, 1, 32'd3, 1);
    nvec++;
    if (sel !== 1'b1 || y !== 32'd3) begin nerr++; $display("FAIL drop_a: got sel=%b y=%0d want sel=1 y=3", sel, y); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 300; i++)
      cycle($urandom_range(0, 30) == 0, 1'($urandom), $urandom, 1'($urandom), $urandom, $urandom_range(0, 3) != 0);
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_stall;
    test_reset_mid;
    test_wrap;
    test_fixed_drop;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mux_arb_2x32.md
MUX_ARB_2X32 -- requirements
Module: mux_arb_2x32

Interface
REQ-001 Parameter: CNT_W, default 16, width of the accepted-word counter XFER_CNT.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 CLK  input  1  rising-edge clock for all state.
REQ-004 RST  input  1  synchronous active-high reset, sampled on CLK rising edge.
REQ-005 A_VALID  input  1  requester A holds a valid word on A.
REQ-006 A  input  32  requester A data.
REQ-007 A_READY  output  1  A word is accepted this cycle (A_VALID & A_READY).
REQ-008 B_VALID  input  1  requester B holds a valid word on B.
REQ-009 B  input  32  requester B data.
REQ-010 B_READY  output  1  B word is accepted this cycle.
REQ-011 Y_VALID  output  1  Y holds a valid word.
REQ-012 Y  output  32  registered output word.
REQ-013 Y_READY  input  1  consumer takes Y this cycle (Y_VALID & Y_READY).
REQ-014 SEL  output  1  source of the word in Y: 0 = A, 1 = B.
REQ-015 XFER_CNT  output  CNT_W  count of accepted words, modulo 2^CNT_W.

Function
REQ-016 Data selection uses one mux_2x32 instance: SEL input = internal grant, A/B inputs = A/B ports, Y feeds the output register.
REQ-017 Output register states: EMPTY (Y_VALID=0) and FULL (Y_VALID=1).
REQ-018 Slot open = EMPTY, or FULL with Y_READY=1 in the same cycle.
REQ-019 Grant (combinational): only A_VALID -> A; only B_VALID -> B; both -> side opposite LAST; neither -> no grant.
REQ-020 A_READY = slot open & grant==A & !RST; B_READY = slot open & grant==B & !RST; never both high.
REQ-021 READY may depend combinationally on VALID and Y_READY; VALID never depends on READY.
REQ-022 On accept: Y <= granted word, SEL <= grant, Y_VALID <= 1, LAST <= grant, XFER_CNT <= XFER_CNT+1; latency 1 cycle from accept to Y_VALID.
REQ-023 FULL with Y_READY=1 and no accept: Y_VALID <= 0; Y and SEL keep their values.
REQ-024 FULL with Y_READY=0: Y, SEL and Y_VALID hold; A_READY = B_READY = 0.
REQ-025 Drain and accept in the same cycle: Y is replaced and Y_VALID stays 1, giving one word per cycle sustained throughput.
REQ-026 XFER_CNT wraps from 2^CNT_W-1 to 0 without flagging.
REQ-027 LAST updates only on accept; an idle cycle does not change arbitration order.

Reset
REQ-028 RST=1 sets Y_VALID=0, Y=0, SEL=0, XFER_CNT=0 and LAST=B, so A wins the first tie.
REQ-029 RST dominates all other inputs, including mid-transfer: any word held in Y is discarded and both READYs are 0 while RST=1.
REQ-030 The first accept is possible in the first cycle with RST=0.

Configuration
REQ-031 Macro MUX_ARB_FIXED_PRI_EN defined: a tie always grants A, LAST is unused, and B is served only when A_VALID=0.
REQ-032 Macro MUX_ARB_FIXED_PRI_EN undefined: round-robin per REQ-019 and REQ-027; REQ-028 applies.

Verification
REQ-033 Reset, then A_VALID=1, A=32'd1, B_VALID=0, Y_READY=1 -> A_READY=1 in cycle 0; next cycle Y=1, SEL=0, Y_VALID=1, XFER_CNT=1.
REQ-034 Both VALID continuously, A=32'd1, B=32'd3, Y_READY=1 (round-robin build) -> Y sequence 1,3,1,3 with SEL 0,1,0,1, one word per cycle.
REQ-035 Y=32'd1 held with Y_READY=0 for 5 cycles while both VALID -> Y/SEL stable, A_READY=B_READY=0; Y_READY=1 -> B word 3 loaded next cycle.
REQ-036 RST asserted for 1 cycle while FULL with Y=32'd3 -> Y_VALID=0, Y=0, XFER_CNT=0; next tie grants A.
REQ-037 CNT_W=4, 17 accepts -> XFER_CNT reads 15 after the 15th accept, 0 after the 16th, 1 after the 17th.
REQ-038 MUX_ARB_FIXED_PRI_EN build, both VALID continuously, Y_READY=1 -> Y always 32'd1, B_READY never 1; drop A_VALID -> B accepted the same cycle.
